// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//            Accepts a request in IDLE, runs 32 shift/subtract iterations and
//            presents the result for one cycle. Latency is 33 cycles from
//            accept to result, with no early termination.
// Ports    : clk       - clock, all state on rising edge
//            reset     - asynchronous active-low reset
//            div_inst  - start request, sampled only in IDLE
//            funct3    - op select (bit0 = unsigned, bit1 = remainder)
//            rs1_data  - dividend
//            rs2_data  - divisor
//            div_kill  - pipeline flush, aborts an operation in progress
//            div_busy  - high while iterating or presenting the result
//            div_last  - one-cycle result strobe
//            Qo        - registered result, held until the next completion
// Revision : 1.0 - initial release
// ============================================================================
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_inst,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        div_kill,
    output logic        div_busy,
    output logic        div_last,
    output logic [31:0] Qo
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ITER = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [4:0] c_LAST_ITER = 5'd31;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [4:0]  r_cnt;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvsr;
    logic        r_sel_rem;
    logic        r_neg_q;
    logic        r_neg_r;

    logic        w_accept;
    logic        w_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [33:0] w_shift;
    logic [33:0] w_trial;
    logic        w_take;
    logic [32:0] w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic        w_finish;
    logic [31:0] w_sel;
    logic        w_neg;
    logic [31:0] w_result;

    // ------------------------------------------------------------------------
    // Request decode and operand conditioning
    // ------------------------------------------------------------------------
    assign w_accept = (r_state == c_ST_IDLE) && div_inst && !div_kill;
    assign w_signed = !funct3[0];

    // Magnitudes are treated as unsigned, so |0x80000000| stays 0x80000000.
    assign w_a_mag = (w_signed && rs1_data[31]) ? (32'd0 - rs1_data) : rs1_data;
    assign w_b_mag = (w_signed && rs2_data[31]) ? (32'd0 - rs2_data) : rs2_data;

    // ------------------------------------------------------------------------
    // One restoring iteration. The shifted partial remainder is kept one bit
    // wider than needed so bit 33 of the difference is a reliable sign.
    // ------------------------------------------------------------------------
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_trial   = w_shift - {2'b00, r_dvsr};
    assign w_take    = !w_trial[33];
    assign w_rem_nxt = w_take ? w_trial[32:0] : w_shift[32:0];
    assign w_quo_nxt = {r_quo[30:0], w_take};

    assign w_finish  = (r_state == c_ST_ITER) && (r_cnt == c_LAST_ITER) && !div_kill;

    // Result is formed from the final iteration's next values so it can be
    // registered on the same edge that enters DONE.
    assign w_sel    = r_sel_rem ? w_rem_nxt[31:0] : w_quo_nxt;
    assign w_neg    = r_sel_rem ? r_neg_r : r_neg_q;
    assign w_result = w_neg ? (32'd0 - w_sel) : w_sel;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_ST_ITER;
                end
            end
            c_ST_ITER: begin
                if (div_kill) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_cnt == c_LAST_ITER) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            // A kill in DONE is ignored: the result is already committed.
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= 5'd0;
            r_rem     <= 33'd0;
            r_quo     <= 32'd0;
            r_dvsr    <= 32'd0;
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            Qo        <= 32'd0;
        end else begin
            if (w_accept) begin
                r_cnt     <= 5'd0;
                r_rem     <= 33'd0;
                r_quo     <= w_a_mag;
                r_dvsr    <= w_b_mag;
                r_sel_rem <= funct3[1];
                // Divide by zero keeps the all-ones quotient un-negated.
                r_neg_q   <= w_signed && (rs1_data[31] ^ rs2_data[31]) && (rs2_data != 32'd0);
                r_neg_r   <= w_signed && rs1_data[31];
            end else if (r_state == c_ST_ITER) begin
                r_cnt <= r_cnt + 5'd1;
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
            end
            if (w_finish) begin
                Qo <= w_result;
            end
        end
    end

    // Outputs decode registered state only.
    assign div_busy = (r_state == c_ST_ITER) || (r_state == c_ST_DONE);
    assign div_last = (r_state == c_ST_DONE);

endmodule
`default_nettype wire
